// File: rtl/riscv_pkg.sv
// Shared RISC-V constants, ALU op encodings, operand selects and the
// pipeline stage record used by alu_issue.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [3:0] aluop_t;

    // SRL/SRA share all bits but bit 0 so the ALU shifter can decode arithmetic from bit 0 alone.
    localparam aluop_t ADD_OP  = 4'd0;
    localparam aluop_t SUB_OP  = 4'd1;
    localparam aluop_t SLL_OP  = 4'd2;
    localparam aluop_t XOR_OP  = 4'd3;
    localparam aluop_t SRL_OP  = 4'd4;
    localparam aluop_t SRA_OP  = 4'd5;
    localparam aluop_t OR_OP   = 4'd6;
    localparam aluop_t AND_OP  = 4'd7;
    localparam aluop_t PASS_OP = 4'd8;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_sel_e;
    typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

    typedef struct packed {
        logic              valid;
        logic              illegal;
        logic [REG_AW-1:0] rd;
        aluop_t            aluop;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
    } stage_t;

    localparam stage_t STAGE_RST = '{valid: 1'b0, illegal: 1'b0, rd: '0,
                                     aluop: ADD_OP, op1: '0, op2: '0};

    // funct3 map shared by OP and OP-IMM; caller masks b5 where it must be ignored.
    function automatic aluop_t funct3_op(input logic [2:0] funct3, input logic b5);
        aluop_t op;
        case (funct3)
            3'b000:  op = b5 ? SUB_OP : ADD_OP;
            3'b001:  op = SLL_OP;
            3'b100:  op = XOR_OP;
            3'b101:  op = b5 ? SRA_OP : SRL_OP;
            3'b110:  op = OR_OP;
            3'b111:  op = AND_OP;
            default: op = PASS_OP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU op, operand
// selects and an illegal flag.
module alu_op_decode
    import riscv_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    output aluop_t     o_aluop,
    output op1_sel_e   o_op1_sel,
    output op2_sel_e   o_op2_sel,
    output logic       o_illegal
);

    logic f3_legal;
    assign f3_legal = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        o_aluop   = PASS_OP;
        o_op1_sel = OP1_ZERO;
        o_op2_sel = OP2_ZERO;
        o_illegal = 1'b1;
        case (i_opcode)
            OPC_OP: if (f3_legal) begin
                o_aluop   = funct3_op(i_funct3, i_funct7_b5);
                o_op1_sel = OP1_RS1;
                o_op2_sel = OP2_RS2;
                o_illegal = 1'b0;
            end
            OPC_OPIMM: if (f3_legal) begin
                o_aluop   = funct3_op(i_funct3, i_funct7_b5 && (i_funct3 != 3'b000));
                o_op1_sel = OP1_RS1;
                o_op2_sel = OP2_IMM;
                o_illegal = 1'b0;
            end
            OPC_LUI: begin
                o_aluop   = PASS_OP;
                o_op2_sel = OP2_IMM;
                o_illegal = 1'b0;
            end
            OPC_AUIPC: begin
                o_aluop   = ADD_OP;
                o_op1_sel = OP1_PC;
                o_op2_sel = OP2_IMM;
                o_illegal = 1'b0;
            end
            OPC_JAL, OPC_JALR: begin
                o_aluop   = ADD_OP;
                o_op1_sel = OP1_PC;
                o_op2_sel = OP2_FOUR;
                o_illegal = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode/operand select into S1, tag copy in S2, operand
// replay under writeback stall. Define ALU_ISSUE_FWD_EN to forward the retiring result.
module alu_issue
    import riscv_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int ALUOP_WIDTH = 4,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [6:0]             i_opcode,
    input  logic [2:0]             i_funct3,
    input  logic                   i_funct7_b5,
    input  logic [DWIDTH-1:0]      i_pc,
    input  logic [DWIDTH-1:0]      i_imm,
    input  logic [DWIDTH-1:0]      i_rs1_data,
    input  logic [DWIDTH-1:0]      i_rs2_data,
    input  logic [RADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [RADDR_WIDTH-1:0] i_rs2_addr,
    input  logic [RADDR_WIDTH-1:0] i_rd,
    output logic [DWIDTH-1:0]      o_op1,
    output logic [DWIDTH-1:0]      o_op2,
    output logic [ALUOP_WIDTH-1:0] o_aluop,
    input  logic [DWIDTH-1:0]      i_alu_result,
    output logic                   o_wb_valid,
    output logic [RADDR_WIDTH-1:0] o_wb_rd,
    output logic                   o_wb_illegal,
    input  logic                   i_wb_ready
);

    stage_t s1_q, s1_d, s2_q, s2_d, drive;
    logic   adv;

    aluop_t   dec_aluop;
    op1_sel_e dec_op1_sel;
    op2_sel_e dec_op2_sel;
    logic     dec_illegal;

    logic [XLEN-1:0] rs1_val, rs2_val, op1_val, op2_val;

    alu_op_decode u_decode (
        .i_opcode   (i_opcode),
        .i_funct3   (i_funct3),
        .i_funct7_b5(i_funct7_b5),
        .o_aluop    (dec_aluop),
        .o_op1_sel  (dec_op1_sel),
        .o_op2_sel  (dec_op2_sel),
        .o_illegal  (dec_illegal)
    );

    assign adv = !s2_q.valid || i_wb_ready;

`ifdef ALU_ISSUE_FWD_EN
    // The retiring S2 result is exactly what i_alu_result holds on the capture edge.
    logic fwd_ok;
    assign fwd_ok  = s2_q.valid && i_wb_ready && !s2_q.illegal && (s2_q.rd != '0);
    assign rs1_val = (fwd_ok && s2_q.rd == REG_AW'(i_rs1_addr)) ? XLEN'(i_alu_result)
                                                                : XLEN'(i_rs1_data);
    assign rs2_val = (fwd_ok && s2_q.rd == REG_AW'(i_rs2_addr)) ? XLEN'(i_alu_result)
                                                                : XLEN'(i_rs2_data);
`else
    logic unused_fwd;
    assign unused_fwd = ^{i_rs1_addr, i_rs2_addr, i_alu_result};
    assign rs1_val    = XLEN'(i_rs1_data);
    assign rs2_val    = XLEN'(i_rs2_data);
`endif

    always_comb begin
        case (dec_op1_sel)
            OP1_RS1: op1_val = rs1_val;
            OP1_PC:  op1_val = XLEN'(i_pc);
            default: op1_val = '0;
        endcase
        case (dec_op2_sel)
            OP2_RS2:  op2_val = rs2_val;
            OP2_IMM:  op2_val = XLEN'(i_imm);
            OP2_FOUR: op2_val = XLEN'(4);
            default:  op2_val = '0;
        endcase
    end

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (adv) begin
            s2_d = s1_q;
            if (i_valid) begin
                s1_d.valid   = 1'b1;
                s1_d.illegal = dec_illegal;
                s1_d.rd      = REG_AW'(i_rd);
                s1_d.aluop   = dec_aluop;
                s1_d.op1     = op1_val;
                s1_d.op2     = op2_val;
            end else begin
                s1_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment; reset clears data too so
        // a reset during a stall leaves no stale operands on the ALU.
        if (reset) begin
            s1_q <= STAGE_RST;
            s2_q <= STAGE_RST;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // While stalled the ALU recomputes S2 so its registered result holds steady.
    assign drive = adv ? s1_q : s2_q;

    assign o_ready      = adv;
    assign o_op1        = DWIDTH'(drive.op1);
    assign o_op2        = DWIDTH'(drive.op2);
    assign o_aluop      = ALUOP_WIDTH'(drive.aluop);
    assign o_wb_valid   = s2_q.valid;
    assign o_wb_rd      = RADDR_WIDTH'(s2_q.rd);
    assign o_wb_illegal = s2_q.illegal;

endmodule
